// File: rtl/bandit_pkg.sv
// bandit_pkg
// Shared definitions for the slot-machine game sequencer: digit and credit
// widths, the game state encoding and the mod-10 fold applied to random
// nibbles before they land on a reel.
package bandit_pkg;

  localparam int DIGIT_W  = 4;
  localparam int CREDIT_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPIN0,
    ST_SPIN1,
    ST_SPIN2,
    ST_EVAL,
    ST_PAYOUT
  } state_t;

  // Folds a 4-bit random value onto a decimal digit: 10..15 become 0..5.
  function automatic logic [DIGIT_W-1:0] mod10(input logic [DIGIT_W-1:0] v);
    return (v > DIGIT_W'(9)) ? v - DIGIT_W'(10) : v;
  endfunction

endpackage

// File: rtl/bandit_game_ctrl_if.sv
// bandit_game_ctrl_if
// Bundles the player inputs, random source and display-side outputs of the
// game sequencer.
//   master : drives coin/start/select/rand_val, observes everything else
//   slave  : the sequencer itself
interface bandit_game_ctrl_if;
  import bandit_pkg::*;

  logic                coin;
  logic                start;
  logic                select;
  logic [DIGIT_W-1:0]  rand_val;
  logic                rand_en;
  logic [DIGIT_W-1:0]  reel0;
  logic [DIGIT_W-1:0]  reel1;
  logic [DIGIT_W-1:0]  reel2;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                win;
  logic [DIGIT_W-1:0]  win_amt;

  modport master (
    output coin, start, select, rand_val,
    input  rand_en, reel0, reel1, reel2, credit, busy, win, win_amt
  );

  modport slave (
    input  coin, start, select, rand_val,
    output rand_en, reel0, reel1, reel2, credit, busy, win, win_amt
  );

endinterface

// File: rtl/bandit_edge_det.sv
// bandit_edge_det
// Registered rising-edge detector for an already synchronous, debounced level.
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : input level
//   rise       : high for one cycle, the cycle after din is first sampled high
module bandit_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync_q, prev_q;

  // Two-stage history of the input; the edge is a fresh 1 over an old 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= din;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/bandit_game_ctrl.sv
// bandit_game_ctrl
// Game sequencer for the one-arm-bandit: keeps the credit count and the three
// reel digits, runs start -> spin -> stop x3 -> evaluate -> payout, and gates
// the random generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bandit_game_ctrl_if.slave (coin/start/select/rand_val in;
//                rand_en, reel0..2, credit, busy, win, win_amt out)
// Optional build macro BANDIT_AUTO_STOP_EN: a reel left spinning for 32 ticks
// stops by itself as if select had risen.
module bandit_game_ctrl
  import bandit_pkg::*;
#(
  parameter int TICK_DIV   = 8,
  parameter int MAX_CREDIT = 99,
  parameter int PAY_TRIPLE = 8,
  parameter int PAY_PAIR   = 2
) (
  input logic               clk,
  input logic               rst_n,
  bandit_game_ctrl_if.slave bus
);

  localparam int TICK_W = $clog2(TICK_DIV);

  logic coin_rise, start_rise, select_rise;

  bandit_edge_det u_coin_det   (.clk(clk), .rst_n(rst_n), .din(bus.coin),   .rise(coin_rise));
  bandit_edge_det u_start_det  (.clk(clk), .rst_n(rst_n), .din(bus.start),  .rise(start_rise));
  bandit_edge_det u_select_det (.clk(clk), .rst_n(rst_n), .din(bus.select), .rise(select_rise));

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DIGIT_W-1:0]  reel_q [3];
  logic [DIGIT_W-1:0]  reel_d [3];
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [DIGIT_W-1:0]  win_amt_q, win_amt_d;
  logic                win_q, win_d;
  logic                busy_q, busy_d;
  logic                rand_en_q, rand_en_d;
`ifdef BANDIT_AUTO_STOP_EN
  logic [5:0]          auto_q, auto_d;
`endif

  logic                tick;
  logic                stop;
  logic [CREDIT_W:0]   sum;
  int                  cur;

  // Next-state logic. Credit changes from coin, start and payout are summed
  // in one widened value and saturated once, so simultaneous events combine
  // naturally. Reels at or above the current stop index reload on each tick;
  // the reel being stopped keeps its value even if the tick coincides.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    reel_d    = reel_q;
    win_amt_d = win_amt_q;
    win_d     = 1'b0;
    stop      = 1'b0;
    cur       = 0;
    tick      = (tick_q == TICK_W'(TICK_DIV - 1));
    sum       = {1'b0, credit_q} + {{CREDIT_W{1'b0}}, coin_rise};
`ifdef BANDIT_AUTO_STOP_EN
    auto_d    = auto_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_rise && credit_q != '0) begin
          sum     = sum - (CREDIT_W+1)'(1);
          tick_d  = '0;
`ifdef BANDIT_AUTO_STOP_EN
          auto_d  = '0;
`endif
          state_d = ST_SPIN0;
        end
      end
      ST_SPIN0, ST_SPIN1, ST_SPIN2: begin
        cur    = (state_q == ST_SPIN0) ? 0 : (state_q == ST_SPIN1) ? 1 : 2;
        tick_d = tick ? '0 : tick_q + TICK_W'(1);
        stop   = select_rise;
`ifdef BANDIT_AUTO_STOP_EN
        if (tick && auto_q == 6'd31) stop = 1'b1;
        if (stop)      auto_d = '0;
        else if (tick) auto_d = auto_q + 6'd1;
`endif
        if (tick) begin
          for (int i = 0; i < 3; i++) begin
            if (i > cur || (i == cur && !stop)) reel_d[i] = mod10(bus.rand_val);
          end
        end
        if (stop) begin
          case (state_q)
            ST_SPIN0: state_d = ST_SPIN1;
            ST_SPIN1: state_d = ST_SPIN2;
            default:  state_d = ST_EVAL;
          endcase
        end
      end
      ST_EVAL: begin
        if (reel_q[0] == reel_q[1] && reel_q[1] == reel_q[2])
          win_amt_d = DIGIT_W'(PAY_TRIPLE);
        else if (reel_q[0] == reel_q[1] || reel_q[1] == reel_q[2] || reel_q[0] == reel_q[2])
          win_amt_d = DIGIT_W'(PAY_PAIR);
        else
          win_amt_d = '0;
        state_d = ST_PAYOUT;
      end
      ST_PAYOUT: begin
        sum     = sum + (CREDIT_W+1)'(win_amt_q);
        win_d   = (win_amt_q != '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    credit_d  = (sum > (CREDIT_W+1)'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT) : sum[CREDIT_W-1:0];
    busy_d    = (state_d != ST_IDLE);
    rand_en_d = (state_d != ST_EVAL) && (state_d != ST_PAYOUT);
  end

  // State and registered outputs; reset returns everything to an idle,
  // zero-credit machine with the generator enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      reel_q    <= '{default: '0};
      credit_q  <= '0;
      win_amt_q <= '0;
      win_q     <= 1'b0;
      busy_q    <= 1'b0;
      rand_en_q <= 1'b1;
`ifdef BANDIT_AUTO_STOP_EN
      auto_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      reel_q    <= reel_d;
      credit_q  <= credit_d;
      win_amt_q <= win_amt_d;
      win_q     <= win_d;
      busy_q    <= busy_d;
      rand_en_q <= rand_en_d;
`ifdef BANDIT_AUTO_STOP_EN
      auto_q    <= auto_d;
`endif
    end
  end

  assign bus.reel0   = reel_q[0];
  assign bus.reel1   = reel_q[1];
  assign bus.reel2   = reel_q[2];
  assign bus.credit  = credit_q;
  assign bus.win_amt = win_amt_q;
  assign bus.win     = win_q;
  assign bus.busy    = busy_q;
  assign bus.rand_en = rand_en_q;

endmodule

// File: tb/tb_bandit_game_ctrl.sv
// tb_bandit_game_ctrl
// Scoreboard bench for bandit_game_ctrl: each round pushes its expected reels,
// payout and credit when stimulus starts and pops them when the machine
// returns to idle.
module tb_bandit_game_ctrl;
  import bandit_pkg::*;

  typedef struct {
    int r0, r1, r2, amt, credit;
    bit win;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_credit = 0;
  exp_t sb[$];
  int   cred_sb[$];

  bandit_game_ctrl_if bus();

  bandit_game_ctrl #(
    .TICK_DIV(8), .MAX_CREDIT(99), .PAY_TRIPLE(8), .PAY_PAIR(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is ever bypassed.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    bus.coin = 0; bus.start = 0; bus.select = 0; bus.rand_val = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    model_credit = 0;
    sb.delete();
    cred_sb.delete();
  endtask

  // which: 0 coin, 1 start, 2 select; one cycle high, one cycle low
  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) bus.coin = 1; else if (which == 1) bus.start = 1; else bus.select = 1;
    @(negedge clk);
    bus.coin = 0; bus.start = 0; bus.select = 0;
  endtask

  task automatic add_coin();
    pulse(0);
    model_credit = (model_credit + 1 > 99) ? 99 : model_credit + 1;
  endtask

  task automatic test_reset();
    bus.coin = 0; bus.start = 0; bus.select = 0; bus.rand_val = 0;
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.reel0, bus.reel1, bus.reel2} !== 12'h000) begin
      n_fail++; $display("[TB] FAIL reset_reels: got %h required 000", {bus.reel0, bus.reel1, bus.reel2});
    end
    n_checks++;
    if (bus.credit !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_credit: got %0d required 0", bus.credit); end
    n_checks++;
    if (bus.win_amt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_win_amt: got %0d required 0", bus.win_amt); end
    n_checks++;
    if (bus.win !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_win: got %b required 0", bus.win); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b required 0", bus.busy); end
    n_checks++;
    if (bus.rand_en !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rand_en: got %b required 1", bus.rand_en); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_coin();
    int got;
    do_reset();
    repeat (3) add_coin();
    cred_sb.push_back(model_credit);
    @(negedge clk);
    got = bus.credit;
    n_checks++;
    if (cred_sb.pop_front() !== got) begin n_fail++; $display("[TB] FAIL coin_three: got %0d required 3", got); end
    repeat (120) add_coin();
    cred_sb.push_back(model_credit);
    @(negedge clk);
    got = bus.credit;
    n_checks++;
    if (cred_sb.pop_front() !== got) begin n_fail++; $display("[TB] FAIL coin_saturate: got %0d required 99", got); end
  endtask

  task automatic test_start_no_credit();
    do_reset();
    bus.rand_val = 5;
    pulse(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL nocredit_busy: got %b required 0", bus.busy); end
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if ({bus.reel0, bus.reel1, bus.reel2, 1'b0, bus.credit} !== 20'h0) begin
      n_fail++; $display("[TB] FAIL nocredit_state: reels %h credit %0d required 000 and 0",
                         {bus.reel0, bus.reel1, bus.reel2}, bus.credit);
    end
  endtask

  task automatic run_round(input string name, input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2);
    exp_t e;
    int   lat;
    bit   done, win_seen;
    logic ren_eval;
    e.r0 = int'(v0) % 10; e.r1 = int'(v1) % 10; e.r2 = int'(v2) % 10;
    if (e.r0 == e.r1 && e.r1 == e.r2) e.amt = 8;
    else if (e.r0 == e.r1 || e.r1 == e.r2 || e.r0 == e.r2) e.amt = 2;
    else e.amt = 0;
    model_credit = model_credit - 1 + e.amt;
    if (model_credit > 99) model_credit = 99;
    e.credit = model_credit;
    e.win    = (e.amt != 0);
    sb.push_back(e);

    bus.rand_val = v0;
    pulse(1);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.rand_en} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL %s_spin_start: busy/rand_en %b required 11", name, {bus.busy, bus.rand_en});
    end
    repeat (12) @(negedge clk);
    pulse(2);
    bus.rand_val = v1;
    repeat (12) @(negedge clk);
    pulse(2);
    bus.rand_val = v2;
    repeat (12) @(negedge clk);
    pulse(2);

    done = 0; win_seen = 0; lat = 0; ren_eval = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) ren_eval = bus.rand_en;
      if (bus.win) win_seen = 1;
      if (!bus.busy) begin done = 1; lat = i; break; end
    end
    n_checks++;
    if (!done) begin n_fail++; $display("[TB] FAIL %s_timeout: busy still 1 after 20 cycles, required 0", name); end
    n_checks++;
    if (lat != 3) begin n_fail++; $display("[TB] FAIL %s_latency: got %0d cycles required 3", name, lat); end
    n_checks++;
    if (ren_eval !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_rand_en_eval: got %b required 0", name, ren_eval); end

    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL %s_scoreboard: got empty queue required one entry", name);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (bus.reel0 !== 4'(e.r0) || bus.reel1 !== 4'(e.r1) || bus.reel2 !== 4'(e.r2)) begin
        n_fail++; $display("[TB] FAIL %s_reels: got %0d/%0d/%0d required %0d/%0d/%0d",
                           name, bus.reel0, bus.reel1, bus.reel2, e.r0, e.r1, e.r2);
      end
      n_checks++;
      if (bus.win_amt !== 4'(e.amt)) begin n_fail++; $display("[TB] FAIL %s_win_amt: got %0d required %0d", name, bus.win_amt, e.amt); end
      n_checks++;
      if (bus.credit !== 7'(e.credit)) begin n_fail++; $display("[TB] FAIL %s_credit: got %0d required %0d", name, bus.credit, e.credit); end
      n_checks++;
      if (win_seen != e.win) begin n_fail++; $display("[TB] FAIL %s_win_pulse: got %b required %b", name, win_seen, e.win); end
    end
    @(negedge clk);
    n_checks++;
    if (bus.win !== 1'b0) begin n_fail++; $display("[TB] FAIL %s_win_width: got %b required 0", name, bus.win); end
  endtask

  task automatic test_rounds();
    do_reset();
    add_coin();
    run_round("triple", 4'd7, 4'd7, 4'd7);
    run_round("pair", 4'd13, 4'd13, 4'd4);
    run_round("nowin", 4'd12, 4'd4, 4'd9);
  endtask

  task automatic test_payout_saturate();
    while (model_credit < 99) add_coin();
    run_round("sat", 4'd7, 4'd7, 4'd7);
  endtask

  task automatic test_coin_with_start_and_reset();
    do_reset();
    add_coin();
    add_coin();
    bus.rand_val = 6;
    @(negedge clk);
    bus.coin = 1; bus.start = 1;
    @(negedge clk);
    bus.coin = 0; bus.start = 0;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.credit} !== {1'b1, 7'd2}) begin
      n_fail++; $display("[TB] FAIL coin_start: busy %b credit %0d required 1 and 2", bus.busy, bus.credit);
    end
    repeat (12) @(negedge clk);
    pulse(2);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.reel0} !== {1'b1, 4'd6}) begin
      n_fail++; $display("[TB] FAIL spin1_before_reset: busy %b reel0 %0d required 1 and 6", bus.busy, bus.reel0);
    end
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({bus.reel0, bus.reel1, bus.reel2, bus.credit, bus.win_amt, bus.win, bus.busy, bus.rand_en} !==
        {12'h000, 7'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("[TB] FAIL midspin_reset: reels %h credit %0d busy %b rand_en %b required 000/0/0/1",
                         {bus.reel0, bus.reel1, bus.reel2}, bus.credit, bus.busy, bus.rand_en);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

`ifdef BANDIT_AUTO_STOP_EN
  task automatic test_auto_stop();
    bit done, win_seen;
    do_reset();
    add_coin();
    bus.rand_val = 5;
    pulse(1);
    done = 0; win_seen = 0;
    for (int i = 0; i < 3 * 32 * 8 + 100; i++) begin
      @(negedge clk);
      if (bus.win) win_seen = 1;
      if (i > 2 && !bus.busy) begin done = 1; break; end
    end
    n_checks++;
    if (!done) begin n_fail++; $display("[TB] FAIL auto_stop_timeout: busy still 1, required 0"); end
    n_checks++;
    if ({bus.reel0, bus.reel1, bus.reel2, bus.win_amt, bus.credit, win_seen} !== {12'h555, 4'd8, 7'd8, 1'b1}) begin
      n_fail++; $display("[TB] FAIL auto_stop_result: reels %h amt %0d credit %0d win %b required 555/8/8/1",
                         {bus.reel0, bus.reel1, bus.reel2}, bus.win_amt, bus.credit, win_seen);
    end
  endtask
`else
  task automatic test_no_auto_stop();
    do_reset();
    add_coin();
    bus.rand_val = 3;
    pulse(1);
    repeat (40 * 8 + 20) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.reel2} !== {1'b1, 4'd3}) begin
      n_fail++; $display("[TB] FAIL no_auto_stop: busy %b reel2 %0d required 1 and 3", bus.busy, bus.reel2);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_coin();
    test_start_no_credit();
    test_rounds();
    test_payout_saturate();
    test_coin_with_start_and_reset();
`ifdef BANDIT_AUTO_STOP_EN
    test_auto_stop();
`else
    test_no_auto_stop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
